touch_irq_scheduler: RTL
========================

TOUCH_IRQ_SCHEDULER -- requirements
Module: touch_irq_scheduler

Interface
REQ-001 Parameter DEBOUNCE, default 4, consecutive clk cycles a changed input level must persist before the filtered level follows; legal range 1..255.
REQ-002 Parameter HOLDOFF_W, default 16, width of the holdoff counter and holdoff register field.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 touch_int_n  input  1  asynchronous active-low interrupt line from touch panel.
REQ-006 address  input  2  Avalon slave word address.
REQ-007 chipselect  input  1  Avalon slave select.
REQ-008 write_n  input  1  Avalon write strobe, active-low.
REQ-009 writedata  input  32  Avalon write data.
REQ-010 readdata  output  32  Avalon read data, registered, 1-cycle latency, unused bits 0.
REQ-011 rd_req  output  1  request to touch-read engine to fetch one touch report.
REQ-012 rd_ack  input  1  single-cycle completion pulse from touch-read engine.
REQ-013 irq  output  1  level interrupt to CPU.

Function
REQ-014 Synchronizer: two flops on touch_int_n, both reset to 1; s2 is synchronized level.
REQ-015 Debounce: filtered level f (reset 1) inverts only after s2 != f for DEBOUNCE consecutive cycles; counter clears whenever s2 == f.
REQ-016 Event: f transition 1->0 while CTRL.enable=1 yields one event pulse; events while enable=0 discarded.
REQ-017 Pending counter: 4 bits, reset 0, +1 per event, saturates at 15; event at 15 sets sticky STATUS.ovf.
REQ-018 Event and dispatch in same cycle: pending net unchanged; at 15 no overflow flagged.
REQ-019 FSM states IDLE, REQ, HOLD; reset state IDLE.
REQ-020 IDLE -> REQ when pending != 0 and enable=1; pending decrements by 1 on that transition.
REQ-021 REQ: rd_req=1 (registered output, reset 0, asserted first cycle in REQ); on rd_ack=1 -> HOLD, rd_req drops next cycle.
REQ-022 On leaving REQ: done counter (32 bits, reset 0, wraps 0xFFFFFFFF->0) +1; irq_pend set.
REQ-023 HOLD: holdoff counter loaded with HOLDOFF value on entry, decrements; -> IDLE when counter is 0; HOLDOFF=0 gives exactly 1 HOLD cycle.
REQ-024 rd_ack outside REQ ignored.
REQ-025 Clearing enable mid-REQ: current request completes normally; no further dispatch; pending retained.
REQ-026 irq = irq_pend & CTRL.irq_en, combinational from registers.
REQ-027 Register map (address): 0 STATUS RO/W1C, 1 CTRL RW, 2 HOLDOFF RW, 3 DONE_COUNT RO.
REQ-028 STATUS: bit0 irq_pend, bit1 f, bit2 ovf, bit3 busy (state != IDLE), bits7:4 pending.
REQ-029 Write STATUS: writedata bit0=1 clears irq_pend, bit2=1 clears ovf; same-cycle set wins over clear.
REQ-030 CTRL: bit0 enable, bit1 irq_en; reset 0. HOLDOFF: bits HOLDOFF_W-1:0, reset 0.
REQ-031 Write to DONE_COUNT: no effect.
REQ-032 readdata updates every cycle from current address, irrespective of chipselect.

Reset
REQ-033 reset_n low: all flops to reset values immediately; rd_req=0, irq=0, readdata=0, state IDLE, sync flops and f =1.
REQ-034 Reset mid-REQ abandons the request; a rd_ack after reset release is ignored.

Verification
REQ-035 enable=1, irq_en=1, HOLDOFF=3; touch_int_n low 10 cycles -> rd_req rises 2+4+2 cycles after falling edge; rd_ack -> DONE_COUNT=1, irq=1; write STATUS 0x1 -> irq=0.
REQ-036 Glitch: touch_int_n low 3 cycles (DEBOUNCE=4) -> no event, pending 0, rd_req never asserted.
REQ-037 enable=1, rd_ack withheld; 17 debounced falling edges -> one in REQ, pending=15, STATUS.ovf=1; W1C bit2 clears ovf only.
REQ-038 HOLDOFF=0, three queued events, rd_ack same cycle rd_req seen -> rd_req pulses separated by exactly 2 low cycles (HOLD, IDLE); DONE_COUNT=3.
REQ-039 Clear enable while in REQ with pending=2 -> rd_ack completes it, DONE_COUNT +1, pending stays 2, rd_req stays 0 until re-enabled.
REQ-040 Assert reset_n low during REQ -> rd_req=0, readdata=0 same cycle; post-release rd_ack leaves DONE_COUNT=0.

Source files
------------

// File: rtl/touch_irq_scheduler.sv
// rtl/touch_irq_scheduler.sv - touch interrupt debounce, report-fetch dispatcher and CPU irq
// Queues debounced touch events and hands them to the touch-read engine one at a time.
module touch_irq_scheduler #(
  parameter int DEBOUNCE  = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        touch_int_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rd_req,
  input  logic        rd_ack,
  output logic        irq
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 sync1;
  logic                 sync2;
  logic [7:0]           db_cnt;
  logic                 filt;
  logic                 filt_d;
  logic [3:0]           pending;
  logic                 ovf;
  logic                 irq_pend;
  logic                 enable;
  logic                 irq_en;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [31:0]          done_cnt;
  logic [31:0]          rd_mux;
  logic                 dispatch;
  logic                 complete;
  logic                 touch_event;
  logic                 wr_en;
  logic                 wr_status;
  logic                 wr_ctrl;
  logic                 wr_holdoff;
  logic                 busy;

  assign wr_en       = chipselect & ~write_n;
  assign wr_status   = wr_en && (address == 2'd0);
  assign wr_ctrl     = wr_en && (address == 2'd1);
  assign wr_holdoff  = wr_en && (address == 2'd2);
  assign touch_event = filt_d & ~filt & enable;
  assign busy        = (state != ST_IDLE);
  assign irq         = irq_pend & irq_en;

  // Synchronizer and debounce filter; the filtered level idles high like the line itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      db_cnt <= 8'd0;
    end else begin
      sync1  <= touch_int_n;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 == filt) begin
        db_cnt <= 8'd0;
      end else if (db_cnt == DB_LAST) begin
        filt   <= ~filt;
        db_cnt <= 8'd0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dispatch  = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pending != 4'd0) && enable) begin
          state_nxt = ST_REQ;
          dispatch  = 1'b1;
        end
      end
      ST_REQ: begin
        if (rd_ack) begin
          state_nxt = ST_HOLD;
          complete  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rd_req   <= 1'b0;
      hold_cnt <= '0;
      done_cnt <= 32'd0;
    end else begin
      state  <= state_nxt;
      rd_req <= (state_nxt == ST_REQ);
      if (complete) begin
        hold_cnt <= holdoff;
      end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      done_cnt <= done_cnt + 32'(complete);
    end
  end

  // A simultaneous event and dispatch cancel out, so a full queue does not overflow then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 4'd0;
      ovf     <= 1'b0;
    end else begin
      if (touch_event && !dispatch) begin
        if (pending != 4'hf) begin
          pending <= pending + 4'd1;
        end
      end else if (dispatch && !touch_event) begin
        pending <= pending - 4'd1;
      end
      if (touch_event && !dispatch && (pending == 4'hf)) begin
        ovf <= 1'b1;
      end else if (wr_status && writedata[2]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      holdoff  <= '0;
    end else begin
      if (complete) begin
        irq_pend <= 1'b1;
      end else if (wr_status && writedata[0]) begin
        irq_pend <= 1'b0;
      end
      if (wr_ctrl) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
      end
      if (wr_holdoff) begin
        holdoff <= writedata[HOLDOFF_W-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      2'd0:    rd_mux = {24'd0, pending, busy, ovf, filt, irq_pend};
      2'd1:    rd_mux = {30'd0, irq_en, enable};
      2'd2:    rd_mux[HOLDOFF_W-1:0] = holdoff;
      default: rd_mux = done_cnt;
    endcase
  end

  // Read data tracks the address every cycle; chipselect only qualifies writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
